// File: rtl/floydwarshall_main_if.sv
// Slave/master byte bus of the Floyd-Warshall accelerator: two 8-bit channels per direction.
interface floydwarshall_main_if;
    logic [1:0]  S_oe_ram;
    logic [1:0]  S_we_ram;
    logic [21:0] S_addr_ram;
    logic [15:0] S_Wdata_ram;
    logic [7:0]  S_data_ram_size;
    logic [15:0] M_Rdata_ram;
    logic [1:0]  M_DataRdy;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;
    logic [1:0]  Mout_oe_ram;
    logic [1:0]  Mout_we_ram;
    logic [21:0] Mout_addr_ram;
    logic [15:0] Mout_Wdata_ram;
    logic [7:0]  Mout_data_ram_size;

    modport slave (
        input  S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
        input  M_Rdata_ram, M_DataRdy,
        output Sout_Rdata_ram, Sout_DataRdy,
        output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size
    );

    modport master (
        output S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
        output M_Rdata_ram, M_DataRdy,
        input  Sout_Rdata_ram, Sout_DataRdy,
        input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size
    );
endinterface

// File: rtl/floydwarshall_main.sv
// All-pairs shortest paths over a 16x16 byte matrix held in a dual-port on-chip RAM,
// with a two-channel slave port for host access while idle.
module floydwarshall_main #(
    parameter int unsigned MEM_var_28859_28864 = 512
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_port,
    output logic                  done_port,
    floydwarshall_main_if.slave   bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ROW   = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state;
    logic [3:0]  k, i, j;
    logic [7:0]  d_ik, d_ij, d_kj;
    logic [8:0]  sum;
    logic        serving;

    logic [7:0]  a0, a1, wd0, wd1, rd0, rd1;
    logic        we0, we1;

    logic [31:0] rel0, rel1;
    logic [1:0]  hit;
    logic [7:0]  mask0, mask1;
    logic [1:0]  rdy_q;
    logic [15:0] rdata_q;
    logic        unused_m;

    // The array holds contents XOR W, so a zero-initialised array powers up holding W.
    logic [7:0]  delta [256];

    function automatic logic [7:0] wgt(input logic [7:0] a);
        logic [9:0] s;
        logic [9:0] m;
        s = 10'd7 * {6'd0, a[7:4]} + 10'd13 * {6'd0, a[3:0]};
        m = s % 10'd60;
        return (a[7:4] == a[3:0]) ? 8'd0 : 8'(m) + 8'd1;
    endfunction

    function automatic logic [7:0] mask_of(input logic [3:0] sz);
        logic [8:0] m;
        m = (9'd1 << sz) - 9'd1;
        return (sz >= 4'd8) ? 8'hFF : 8'(m);
    endfunction

    assign serving = (state == S_IDLE) || (state == S_DONE);
    assign sum     = {1'b0, d_ik} + {1'b0, d_kj};

    // Below-base addresses wrap to large values, so one compare covers both bounds.
    assign rel0  = {21'd0, bus.S_addr_ram[10:0]}  - MEM_var_28859_28864;
    assign rel1  = {21'd0, bus.S_addr_ram[21:11]} - MEM_var_28859_28864;
    assign hit   = {rel1 < 32'd256, rel0 < 32'd256};
    assign mask0 = mask_of(bus.S_data_ram_size[3:0]);
    assign mask1 = mask_of(bus.S_data_ram_size[7:4]);

    always_comb begin
        a0 = rel0[7:0];
        a1 = rel1[7:0];
        unique case (state)
            S_INIT, S_READ, S_WRITE: a0 = {i, j};
            S_ROW:                   a0 = {i, k};
            default:                 ;
        endcase
        if (state == S_READ) a1 = {k, j};
    end

    assign rd0 = delta[a0] ^ wgt(a0);
    assign rd1 = delta[a1] ^ wgt(a1);

    always_comb begin
        we0 = 1'b0;
        we1 = 1'b0;
        wd0 = (bus.S_Wdata_ram[7:0]  & mask0) | (rd0 & ~mask0);
        wd1 = (bus.S_Wdata_ram[15:8] & mask1) | (rd1 & ~mask1);
        unique case (state)
            S_INIT: begin
                we0 = 1'b1;
                wd0 = wgt(a0);
            end
            S_WRITE: begin
                we0 = (sum < {1'b0, d_ij});
                wd0 = sum[7:0];
            end
            S_IDLE, S_DONE: begin
                we0 = bus.S_we_ram[0] & hit[0];
                we1 = bus.S_we_ram[1] & hit[1];
            end
            default: ;
        endcase
    end

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clock) begin
        if (we0) delta[a0] <= wd0 ^ wgt(a0);
        if (we1) delta[a1] <= wd1 ^ wgt(a1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            k         <= '0;
            i         <= '0;
            j         <= '0;
            d_ik      <= '0;
            d_ij      <= '0;
            d_kj      <= '0;
            done_port <= 1'b0;
        end else begin
            done_port <= (state == S_DONE);
            unique case (state)
                S_IDLE: begin
                    if (start_port) begin
                        state <= S_INIT;
                        k     <= '0;
                        i     <= '0;
                        j     <= '0;
                    end
                end
                S_INIT: begin
                    {i, j} <= {i, j} + 8'd1;
                    if ({i, j} == 8'hFF) state <= S_ROW;
                end
                S_ROW: begin
                    d_ik  <= rd0;
                    state <= S_READ;
                end
                S_READ: begin
                    d_ij  <= rd0;
                    d_kj  <= rd1;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    j <= j + 4'd1;
                    if (j != 4'hF) begin
                        state <= S_READ;
                    end else begin
                        i <= i + 4'd1;
                        if (i != 4'hF) begin
                            state <= S_ROW;
                        end else begin
                            k     <= k + 4'd1;
                            state <= (k == 4'hF) ? S_DONE : S_ROW;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // A busy-time hit still acknowledges, but returns zero and drops the write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdy_q   <= '0;
            rdata_q <= '0;
        end else begin
            rdy_q         <= (bus.S_oe_ram | bus.S_we_ram) & hit;
            rdata_q[7:0]  <= (serving && bus.S_oe_ram[0] && !bus.S_we_ram[0] && hit[0]) ? rd0 : '0;
            rdata_q[15:8] <= (serving && bus.S_oe_ram[1] && !bus.S_we_ram[1] && hit[1]) ? rd1 : '0;
        end
    end

    assign bus.Sout_DataRdy       = rdy_q;
    assign bus.Sout_Rdata_ram     = rdata_q;
    assign bus.Mout_oe_ram        = '0;
    assign bus.Mout_we_ram        = '0;
    assign bus.Mout_addr_ram      = '0;
    assign bus.Mout_Wdata_ram     = '0;
    assign bus.Mout_data_ram_size = '0;
    assign unused_m               = ^{bus.M_Rdata_ram, bus.M_DataRdy};

endmodule

// File: tb/tb_floydwarshall_main.sv
// Self-checking bench for floydwarshall_main: bus reads/writes against a memory model
// and full runs against a software Floyd-Warshall of the initial weight matrix.
module tb_floydwarshall_main;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start_port = 1'b0;
    logic done_port;

    floydwarshall_main_if bus ();

    floydwarshall_main #(.MEM_var_28859_28864(512)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_port (start_port),
        .done_port  (done_port),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int w [256];
    int fw [256];
    int model [256];
    int rb [256];
    int mout_errs = 0;
    int done_cnt = 0;

    always @(negedge clock) begin
        if ({bus.Mout_oe_ram, bus.Mout_we_ram, bus.Mout_addr_ram,
             bus.Mout_Wdata_ram, bus.Mout_data_ram_size} !== '0) mout_errs++;
        if (done_port === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.S_oe_ram = '0;
        bus.S_we_ram = '0;
        bus.S_addr_ram = '0;
        bus.S_Wdata_ram = '0;
        bus.S_data_ram_size = '0;
    endtask

    task automatic drive(input int ch, input bit rd, input bit wr, input int addr,
                         input int size, input int data);
        if (ch == 0) begin
            bus.S_oe_ram[0] = rd;
            bus.S_we_ram[0] = wr;
            bus.S_addr_ram[10:0] = addr[10:0];
            bus.S_Wdata_ram[7:0] = data[7:0];
            bus.S_data_ram_size[3:0] = size[3:0];
        end else begin
            bus.S_oe_ram[1] = rd;
            bus.S_we_ram[1] = wr;
            bus.S_addr_ram[21:11] = addr[10:0];
            bus.S_Wdata_ram[15:8] = data[7:0];
            bus.S_data_ram_size[7:4] = size[3:0];
        end
    endtask

    task automatic rd_chk(input int ch, input int addr, input int exp, input bit exp_rdy,
                          input string tag);
        bus_idle();
        drive(ch, 1'b1, 1'b0, addr, 8, 0);
        step();
        bus_idle();
        chk({tag, " rdy"}, bus.Sout_DataRdy, exp_rdy ? (1 << ch) : 0);
        chk({tag, " data"}, bus.Sout_Rdata_ram, exp << (8 * ch));
    endtask

    task automatic wr_chk(input int ch, input int addr, input int size, input int data,
                          input bit exp_rdy, input string tag);
        bus_idle();
        drive(ch, 1'b0, 1'b1, addr, size, data);
        step();
        bus_idle();
        chk({tag, " rdy"}, bus.Sout_DataRdy, exp_rdy ? (1 << ch) : 0);
    endtask

    function automatic int merge(input int old, input int data, input int size);
        int mask;
        mask = (size >= 8) ? 255 : (1 << size) - 1;
        return (data & mask) | (old & ~mask & 255);
    endfunction

    task automatic readback_all(input string tag);
        for (int a = 0; a < 256; a++) begin
            rd_chk(a % 2, 512 + a, fw[a], 1'b1, $sformatf("%s[%0d]", tag, a));
            rb[a] = (a % 2 == 0) ? int'(bus.Sout_Rdata_ram[7:0]) : int'(bus.Sout_Rdata_ram[15:8]);
        end
    endtask

    task automatic pulse_start();
        start_port = 1'b1;
        step();
        start_port = 1'b0;
    endtask

    initial begin
        int n, diag_bad, w_bad, tri_bad, a, ch, sz, d, dc;
        bus_idle();
        bus.M_Rdata_ram = '0;
        bus.M_DataRdy = '0;

        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                w[16 * r + c] = (r == c) ? 0 : ((7 * r + 13 * c) % 60) + 1;
        fw = w;
        for (int kk = 0; kk < 16; kk++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    if (fw[16 * r + kk] + fw[16 * kk + c] < fw[16 * r + c])
                        fw[16 * r + c] = fw[16 * r + kk] + fw[16 * kk + c];
        model = w;

        // Reset state
        repeat (3) step();
        chk("rst done", done_port, 0);
        chk("rst rdy", bus.Sout_DataRdy, 0);
        reset = 1'b1;
        step();
        chk("post-rst done", done_port, 0);
        chk("post-rst rdata", bus.Sout_Rdata_ram, 0);

        // Power-up contents
        rd_chk(0, 513, 14, 1'b1, "pwr 513");
        rd_chk(0, 528, 8, 1'b1, "pwr 528");
        step();
        chk("rdy drops", bus.Sout_DataRdy, 0);
        chk("rdata drops", bus.Sout_Rdata_ram, 0);
        for (int t = 0; t < 8; t++) begin
            a = $urandom_range(0, 255);
            rd_chk($urandom_range(0, 1), 512 + a, w[a], 1'b1, $sformatf("pwr rnd %0d", a));
        end

        // Full run with busy-time accesses
        pulse_start();
        n = 0;
        while (done_port !== 1'b1 && n < 10000) begin
            if (n == 500) drive(0, 1'b1, 1'b0, 600, 8, 0);
            if (n == 600) drive(1, 1'b0, 1'b1, 512 + 5, 8, 8'h99);
            step();
            n++;
            if (n == 501) begin
                chk("busy rd rdy", bus.Sout_DataRdy, 2'b01);
                chk("busy rd data", bus.Sout_Rdata_ram, 0);
                bus_idle();
            end
            if (n == 601) begin
                chk("busy wr rdy", bus.Sout_DataRdy, 2'b10);
                bus_idle();
            end
        end
        chk("run1 latency", n, 8705);
        step();
        chk("run1 done width", done_port, 0);
        readback_all("fw1");

        diag_bad = 0; w_bad = 0; tri_bad = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                if (r == c && rb[16 * r + c] != 0) diag_bad++;
                if (rb[16 * r + c] > w[16 * r + c]) w_bad++;
                for (int kk = 0; kk < 16; kk++)
                    if (rb[16 * r + c] > rb[16 * r + kk] + rb[16 * kk + c]) tri_bad++;
            end
        chk("diag zero", diag_bad, 0);
        chk("le W", w_bad, 0);
        chk("triangle", tri_bad, 0);
        model = fw;

        // Directed and random writes
        wr_chk(1, 529, 8, 8'hAA, 1'b1, "wr AA");
        model[17] = merge(model[17], 8'hAA, 8);
        rd_chk(1, 529, 8'hAA, 1'b1, "rb AA");
        wr_chk(1, 529, 4, 8'h05, 1'b1, "wr 05/4");
        model[17] = merge(model[17], 8'h05, 4);
        rd_chk(0, 529, 8'hA5, 1'b1, "rb A5");

        for (int t = 0; t < 24; t++) begin
            a = $urandom_range(0, 255);
            ch = $urandom_range(0, 1);
            sz = $urandom_range(1, 8);
            d = $urandom_range(0, 255);
            wr_chk(ch, 512 + a, sz, d, 1'b1, $sformatf("rnd wr %0d", t));
            model[a] = merge(model[a], d, sz);
            rd_chk($urandom_range(0, 1), 512 + a, model[a], 1'b1, $sformatf("rnd rb %0d", t));
        end

        // Same-address write on both channels: channel 1 wins
        bus_idle();
        drive(0, 1'b0, 1'b1, 512 + 40, 8, 8'h11);
        drive(1, 1'b0, 1'b1, 512 + 40, 8, 8'h22);
        step();
        bus_idle();
        chk("dual wr rdy", bus.Sout_DataRdy, 2'b11);
        model[40] = 8'h22;
        rd_chk(0, 512 + 40, model[40], 1'b1, "dual rb");

        // Read and write on one channel together: write lands, read returns 0
        bus_idle();
        drive(0, 1'b1, 1'b1, 512 + 77, 8, 8'h5C);
        step();
        bus_idle();
        chk("illegal rdy", bus.Sout_DataRdy, 2'b01);
        chk("illegal data", bus.Sout_Rdata_ram, 0);
        model[77] = 8'h5C;
        rd_chk(1, 512 + 77, model[77], 1'b1, "illegal rb");

        // Range boundaries
        rd_chk(0, 511, 0, 1'b0, "miss 511");
        rd_chk(1, 768, 0, 1'b0, "miss 768");
        wr_chk(0, 511, 8, 8'h77, 1'b0, "wmiss 511");
        wr_chk(1, 768, 8, 8'h77, 1'b0, "wmiss 768");
        rd_chk(0, 512, model[0], 1'b1, "edge 512");
        rd_chk(1, 767, model[255], 1'b1, "edge 767");

        // Reset 1000 cycles into a run
        dc = done_cnt;
        pulse_start();
        repeat (1000) step();
        reset = 1'b0;
        #1;
        chk("abort done", done_port, 0);
        step();
        step();
        reset = 1'b1;
        repeat (8000) step();
        chk("abort no done", done_cnt, dc);
        rd_chk(0, 512, 0, 1'b1, "idle after abort");

        // Fresh run reproduces the first result
        pulse_start();
        n = 0;
        while (done_port !== 1'b1 && n < 10000) begin
            step();
            n++;
        end
        chk("run2 latency", n, 8705);
        step();
        chk("run2 done width", done_port, 0);
        readback_all("fw2");

        chk("mout zero", mout_errs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/floydwarshall_main.md
# floydwarshall_main

- Top-level HLS-style accelerator that runs all-pairs shortest paths (Floyd–Warshall) on a 16×16 matrix of 8-bit distances held in on-chip RAM.
- A single `start_port` pulse launches a run; a single-cycle `done_port` pulse ends it.
- An external master can read and write the matrix through a 2-channel byte slave bus.
- The block never issues accesses of its own on the master bus.

## Interface
- MEM_var_28859_28864, default 512: base byte address of the matrix. Element (i,j) is at base + 16·i + j.
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- start_port  in  1  one-cycle start request
- done_port  out  1  one-cycle completion pulse
- S_oe_ram / S_we_ram  in  2  slave read / write enable, one bit per channel
- S_addr_ram  in  22  channel 0 address in [10:0], channel 1 address in [21:11]
- S_Wdata_ram  in  16  channel 0 write data in [7:0], channel 1 in [15:8]
- S_data_ram_size  in  8  access size in bits, channel 0 in [3:0], channel 1 in [7:4]
- M_Rdata_ram  in  16  master read data (unused)
- M_DataRdy  in  2  master ready (unused)
- Sout_Rdata_ram  out  16  slave read data, per-channel byte lanes
- Sout_DataRdy  out  2  slave access acknowledge
- Mout_oe_ram, Mout_we_ram  out  2 each  master enables, tied 0
- Mout_addr_ram  out  22  master address, tied 0
- Mout_Wdata_ram  out  16  master write data, tied 0
- Mout_data_ram_size  out  8  master access size, tied 0

## Operation
- **Initial weight matrix W:**
  - W(i,i) = 0.
  - For i≠j, W(i,j) = ((7i + 13j) mod 60) + 1, so 1..60.
- **RAM:** 256×8, two ports. Power-up contents are W.
- **FSM states:** IDLE, INIT, ROW, READ, WRITE, DONE.
- **IDLE:** `start_port`=1 moves to INIT.
- **INIT:** writes W into all 256 entries, one per cycle.
- **Compute loops:** k, i, j each run 0..15, k outermost and j innermost.
  - ROW: latch d_ik = D[i][k].
  - READ: port 0 fetches D[i][j], port 1 fetches D[k][j].
  - WRITE: s = d_ik + D[k][j] in 9 bits. If s < D[i][j], write s[7:0] to D[i][j]; otherwise leave it unchanged.
  - After WRITE, go to READ for the next j. When j wraps, go to ROW for the next i or k.
- **End of compute:** after the last (k,i,j) go to DONE. DONE asserts `done_port` for one cycle, then the FSM returns to IDLE.
- **Start handling:** `start_port` is ignored outside IDLE.
- **Slave bus:**
  - A channel access hits when base ≤ addr < base+256. Per-channel mask = (1 << size) − 1.
  - Served only in IDLE and DONE.
  - Hit read: `Sout_Rdata_ram` lane = RAM byte.
  - Hit write: RAM byte = (wdata & mask) | (old & ~mask).
  - A miss, or any access while busy: lane reads 0 and the write is dropped. `Sout_DataRdy` still pulses while busy.
  - Misses never assert `Sout_DataRdy`.
  - Channel 1 has priority on same-address writes.
- All `Mout_*` outputs are constant 0, so there is no combinational path from S_* to Mout_*.

## Timing
- **Reset values:** `done_port`=0, `Sout_DataRdy`=0, `Sout_Rdata_ram`=0, all Mout_*=0, FSM in IDLE. RAM contents are not altered by reset.
- **Reset mid-run:** returns to IDLE immediately with no `done_port` pulse. The matrix is left partially updated.
- **Start:** `start_port` is sampled on the rising edge; INIT begins the next cycle.
- **Latency:** `done_port` is high exactly 256 + 16·16·(1 + 2·16) + 1 = 8705 cycles after the cycle in which start was sampled.
- **Next start:** a new start is accepted in the cycle after `done_port`.
- **Slave access latency:** 1 cycle.
  - `Sout_DataRdy[c]` and read data are valid the cycle after the enable was sampled, and are held for one cycle only.
  - `Sout_Rdata_ram` returns to 0 otherwise.
- **Illegal access:** oe and we both high on one channel is illegal; the write is performed and the read returns 0.

## Test plan
- Reset, then slave-read addresses 512+1 and 528 on channel 0 with size 8 → DataRdy one cycle later, data 14 and 8.
- Pulse start → `done_port` high for exactly one cycle, 8705 cycles later. All Mout_* stay 0 throughout.
- After the run, read all 256 entries:
  - Diagonal entries are 0.
  - Every D[i][j] ≤ W(i,j), and D[i][j] ≤ D[i][k] + D[k][j] for all i, j, k.
  - Values match a software Floyd–Warshall model of W.
- Slave-write 0xAA to address 512+17 via channel 1 (size 8), then read it back → 0xAA. A size-4 write of 0x05 to the same address → 0xA5.
- Access address 511 or 768 → no DataRdy, data 0, RAM unchanged. A read issued mid-run → DataRdy with data 0.
- Assert reset 1000 cycles into a run → no `done_port`. A new start afterwards completes in 8705 cycles with results identical to the first run.
